// File: rtl/bist_pattern_gen_if.sv
// Pattern/response handshake between the BIST engine and the circuit under test.
// The master drives patterns and the slave returns a 1-bit response to each one.
interface bist_pattern_gen_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] pat_out;
    logic             pat_valid;
    logic             pat_ready;
    logic             resp_in;

    modport master (
        output pat_out,
        output pat_valid,
        input  pat_ready,
        input  resp_in
    );

    modport slave (
        input  pat_out,
        input  pat_valid,
        output pat_ready,
        output resp_in
    );
endinterface

// File: rtl/bist_pattern_gen.sv
// BIST pattern source (counter or LFSR) and 16-bit serial signature compactor.
// Optional macro BIST_ALL_ZERO_EN turns LFSR mode into a de Bruijn sequence that includes the all-zero pattern.
module bist_pattern_gen #(
    parameter int unsigned     WIDTH        = 8,
    parameter int unsigned     NUM_PATTERNS = 256,
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(8'h01),
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(8'hB8)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      mode_i,
    bist_pattern_gen_if.master        bus,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [15:0]               signature_o
);

    localparam int unsigned SIG_W = 16;
    localparam int unsigned CNT_W = 16;

    localparam logic [SIG_W-1:0] POLY     = 16'h1021;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic fire_c;
    logic zero_fix_c;
    logic lfsr_fb_c;
    logic sig_fb_c;

    assign fire_c = valid_q & bus.pat_ready;

`ifdef BIST_ALL_ZERO_EN
    // Splices 0..0 in between 10..0 and 0..01 to extend the period to 2^WIDTH.
    assign zero_fix_c = (pat_q[WIDTH-2:0] == '0);
`else
    assign zero_fix_c = 1'b0;
`endif

    assign lfsr_fb_c = (^(pat_q & TAPS)) ^ zero_fix_c;
    assign sig_fb_c  = sig_q[SIG_W-1] ^ bus.resp_in;

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pat_d   = pat_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    mode_d  = mode_i;
                    pat_d   = mode_i ? SEED_EFF : '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    sig_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (fire_c) begin
                    sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_fb_c ? POLY : '0);
                    cnt_d = cnt_q + CNT_W'(1);
                    pat_d = mode_q ? {pat_q[WIDTH-2:0], lfsr_fb_c}
                                   : pat_q + WIDTH'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            pat_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sig_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pat_out   = pat_q;
    assign bus.pat_valid = valid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign signature_o   = sig_q;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Scoreboard bench for bist_pattern_gen: a driver queues expected patterns and signatures from a
// reference model, and a monitor compares every fired pattern and each final signature.
module tb_bist_pattern_gen;

    localparam int unsigned W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        ready = 1'b1;
    logic        noise = 1'b0;
    logic        stall_en = 1'b0;
    logic        busy, done;
    logic [15:0] sig;

    logic        start1 = 1'b0;
    logic        mode1 = 1'b0;
    logic        busy1, done1;
    logic [15:0] sig1;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int last_fire = 0;
    bit en_mon = 1'b0;

    logic [7:0]  pq[$];
    logic [15:0] sq[$];
    logic [7:0]  obs[$];

    bist_pattern_gen_if #(.WIDTH(W)) bus ();
    bist_pattern_gen_if #(.WIDTH(W)) bus1 ();

    // Circuit under test: 8-input AND; the response is scrambled while the pattern is stalled.
    assign bus.pat_ready = ready;
    assign bus.resp_in   = ready ? (&bus.pat_out) : noise;
    // Second CUT: 8-input OR on an always-ready link.
    assign bus1.pat_ready = 1'b1;
    assign bus1.resp_in   = |bus1.pat_out;

    bist_pattern_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .mode_i      (mode),
        .bus         (bus),
        .busy_o      (busy),
        .done_o      (done),
        .signature_o (sig)
    );

    bist_pattern_gen #(.NUM_PATTERNS(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start1),
        .mode_i      (mode1),
        .bus         (bus1),
        .busy_o      (busy1),
        .done_o      (done1),
        .signature_o (sig1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: pattern after p under the stated counter / LFSR rules.
    function automatic logic [7:0] model_next(input logic [7:0] p, input bit m);
        logic [7:0] masked;
        int ones;
        if (!m) return 8'((int'(p) + 1) % 256);
        masked = p & 8'hB8;
        ones = 0;
        for (int b = 0; b < 8; b++) ones += int'(masked[b]);
`ifdef BIST_ALL_ZERO_EN
        if (p == 8'h80) return 8'h00;
        if (p == 8'h00) return 8'h01;
`endif
        return 8'((int'(p) * 2) % 256 + (ones % 2));
    endfunction

    function automatic logic [15:0] model_crc(input logic [15:0] s, input logic r);
        logic [15:0] sh;
        sh = 16'((int'(s) * 2) % 65536);
        return (s[15] != r) ? (sh ^ 16'h1021) : sh;
    endfunction

    // Stall response noise and random backpressure, updated just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        ready = stall_en ? ($urandom_range(0, 99) < 70) : 1'b1;
        noise = 1'($urandom);
    end

    // Monitor: compares fired patterns, stall stability and the signature when done rises.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_pat;
        logic       done_prev;
        prev_stall = 1'b0;
        prev_pat   = '0;
        done_prev  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n && en_mon) begin
                if (prev_stall && bus.pat_valid) chk("stall_hold", 32'(bus.pat_out), 32'(prev_pat));
                if (bus.pat_valid && bus.pat_ready) begin
                    obs.push_back(bus.pat_out);
                    if (pq.size() == 0) chk("unexpected_fire", 32'(pq.size()), 1);
                    else chk("pattern", 32'(bus.pat_out), 32'(pq.pop_front()));
                    last_fire = cyc;
                end
                if (done && !done_prev) begin
                    chk("done_latency", 32'(cyc - last_fire), 1);
                    if (sq.size() == 0) chk("sig_expected", 32'(sq.size()), 1);
                    else chk("signature", 32'(sig), 32'(sq.pop_front()));
                end
                prev_stall = bus.pat_valid && !bus.pat_ready;
            end else begin
                prev_stall = 1'b0;
            end
            prev_pat  = bus.pat_out;
            done_prev = done;
        end
    end

    task automatic run_case(input bit m, input bit stalls, input bit mid_start,
                            output logic [15:0] sig_out);
        logic [7:0]  p;
        logic [15:0] s;
        bit          got;
        pq.delete();
        obs.delete();
        p = m ? 8'h01 : 8'h00;
        s = '0;
        for (int i = 0; i < 256; i++) begin
            pq.push_back(p);
            s = model_crc(s, &p);
            p = model_next(p, m);
        end
        sq.push_back(s);
        stall_en = stalls;
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = ~m;
        @(negedge clk);
        chk("sig_cleared", 32'(sig), 0);
        chk("busy_run", 32'(busy), 1);
        chk("done_low", 32'(done), 0);
        got = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            start = mid_start && (i == 20);
            mode  = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 1);
        chk("pq_drained", 32'(pq.size()), 0);
        chk("busy_after", 32'(busy), 0);
        chk("valid_after", 32'(bus.pat_valid), 0);
        sig_out = sig;
        stall_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("sig_frozen", 32'(sig), 32'(sig_out));
        chk("done_held", 32'(done), 1);
    endtask

    initial begin
        logic [15:0] s_b, s_c, s_d, s_e;
        int zeros, zpos, fires;
        logic [7:0] first1;

        // Reset values, both during and after reset.
        #23;
        chk("rst_valid", 32'(bus.pat_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sig", 32'(sig), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(bus.pat_valid), 0);
        chk("post_rst_pat", 32'(bus.pat_out), 0);
        en_mon = 1'b1;

        // Exhaustive run with an ignored start mid-run.
        run_case(1'b0, 1'b0, 1'b1, s_b);
        chk("exh_sig", 32'(s_b), 32'h1021);

        // Restart from DONE under random backpressure.
        run_case(1'b0, 1'b1, 1'b0, s_c);
        chk("stall_sig_equal", 32'(s_c), 32'(s_b));

        // LFSR run.
        run_case(1'b1, 1'b0, 1'b0, s_d);
        chk("lfsr_count", 32'(obs.size()), 256);
        if (obs.size() == 256) begin
            chk("lfsr_p0", 32'(obs[0]), 32'h01);
            chk("lfsr_p1", 32'(obs[1]), 32'h02);
            chk("lfsr_p2", 32'(obs[2]), 32'h04);
            chk("lfsr_p3", 32'(obs[3]), 32'h08);
            chk("lfsr_p4", 32'(obs[4]), 32'h11);
            zeros = 0;
            zpos  = 0;
            for (int i = 0; i < 256; i++) if (obs[i] == 8'h00) begin zeros++; zpos = i; end
`ifdef BIST_ALL_ZERO_EN
            chk("lfsr_zero_once", 32'(zeros), 1);
            chk("lfsr_p255", 32'(obs[255]), 32'h00);
            if (zpos > 0) chk("zero_after_80", 32'(obs[zpos-1]), 32'h80);
            if (zpos < 255) chk("zero_before_01", 32'(obs[zpos+1]), 32'h01);
`else
            chk("lfsr_no_zero", 32'(zeros), 0);
            chk("lfsr_p255", 32'(obs[255]), 32'h01);
`endif
        end

        // LFSR run under backpressure.
        run_case(1'b1, 1'b1, 1'b0, s_e);
        chk("lfsr_stall_sig", 32'(s_e), 32'(s_d));

        // Asynchronous reset after ten patterns.
        en_mon = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        mode  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.pat_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_sig", 32'(sig), 0);
        chk("arst_pat", 32'(bus.pat_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pq.delete();
        sq.delete();
        @(negedge clk);
        chk("arst_idle", 32'(bus.pat_valid), 0);

        // NUM_PATTERNS = 1 in LFSR mode.
        @(posedge clk); #1;
        start1 = 1'b1;
        mode1  = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        fires  = 0;
        first1 = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus1.pat_valid) begin
                if (fires == 0) first1 = bus1.pat_out;
                fires++;
            end
        end
        chk("one_fires", 32'(fires), 1);
        chk("one_first_pat", 32'(first1), 32'h01);
        chk("one_done", 32'(done1), 1);
        chk("one_busy", 32'(busy1), 0);
        chk("one_sig", 32'(sig1), 32'h1021);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
